cmd_opds_sequencer: RTL
=======================

// Module: cmd_opds_sequencer
// PURPOSE
// - Byte-level front end of the processing path: takes received UART bytes, frames them as command + operands.
// - Generates start_bit, valid_cmd and last_opds for the communication FSM.
// - Honours that FSM's timeout/abort and counter-reset, and writes operands into the operand register file.
// PARAMETERS
// - DATA_W    8  width of rx byte and operand word
// - MAX_OPDS  4  operand register file depth; index width IDX_W = $clog2(MAX_OPDS)
// PORTS
// - clk          in   1        clock
// - rst_n        in   1        reset, asynchronous, active-low
// - rx_valid     in   1        1-cycle strobe, rx_data valid
// - rx_data      in   DATA_W   received byte
// - abort        in   1        time_out or disconnect from FSM/timer; level, sampled each cycle
// - opds_cnt_rst in   1        synchronous clear of sequencer (opds_counter_rst)
// - start_bit    out  1        1-cycle pulse: first byte of frame accepted
// - valid_cmd    out  1        1-cycle pulse: latched opcode is in command table
// - cmd_err      out  1        1-cycle pulse: unknown opcode or (opt.) checksum fail
// - cmd_code     out  DATA_W   latched opcode, held until next start_bit
// - opd_wr_en    out  1        operand write strobe
// - opd_wr_idx   out  IDX_W    operand index 0..n-1
// - opd_wr_data  out  DATA_W   operand byte
// - last_opds    out  1        1-cycle pulse: frame complete
// BEHAVIOUR
// - All outputs registered; reset value 0, state S_IDLE, count 0.
// - Command table (opcode -> n operands): 0x01 WRITE 3, 0x02 READ 2, 0x03 FILL 4, 0x04 PING 1.
// - S_IDLE
//   - rx_valid: latch cmd_code <= rx_data; start_bit = 1 next cycle; -> S_DECODE.
// - S_DECODE (exactly 1 cycle)
//   - Opcode in table: valid_cmd = 1, load remaining = n, count = 0; -> S_COLLECT.
//   - Otherwise: cmd_err = 1; -> S_IDLE.
// - S_COLLECT
//   - Each rx_valid: opd_wr_en = 1, opd_wr_idx = count, opd_wr_data = rx_data; count++.
//   - Write of the operand with index n-1:
//     - Without checksum: last_opds = 1 next cycle; -> S_IDLE.
//     - With checksum: -> S_CHECK.
// - Latency
//   - rx byte -> start_bit/opd_wr_en: 1 cycle.
//   - start_bit -> valid_cmd: 1 cycle.
//   - last operand write -> last_opds: 1 cycle.
// - Priority per cycle: opds_cnt_rst > abort > rx_valid.
//   - opds_cnt_rst or abort in S_DECODE/S_COLLECT/S_CHECK: -> S_IDLE, count = 0, no last_opds, no cmd_err.
//   - Bytes arriving in the same cycle are dropped.
//   - abort in S_IDLE: rx_valid ignored that cycle.
// - rx_valid during S_DECODE: byte dropped (no buffering). Sender spacing >= 2 cycles.
// - count never exceeds MAX_OPDS-1; no wrap possible since n <= MAX_OPDS.
// - Reset mid-frame: outputs 0 immediately, partial operands discarded (register file not cleared).
// CONFIGURATION
// - Macro OPDS_CHECKSUM_EN
//   - Defined: S_CHECK waits for one extra byte. It must equal the XOR of cmd_code and all operands.
//     - Match: last_opds pulse.
//     - Mismatch: cmd_err pulse, no last_opds.
//     - Either case: -> S_IDLE. abort/opds_cnt_rst apply in S_CHECK.
//     - Checksum byte is not written to the register file.
//   - Undefined: S_CHECK and XOR accumulator absent; last_opds follows the last operand directly.
// STRUCTURE
// - Package comm_pkg:
//   - seq_state_t enum {S_IDLE, S_DECODE, S_COLLECT, S_CHECK}
//   - opcode localparams CMD_WRITE/READ/FILL/PING
//   - function opds_for_cmd(opcode) -> count, 0 = invalid
// - Sub-module cmd_table_rom: combinational opcode -> {valid, n_opds}; keeps the table editable in one place.
// - Everything else in a single always_ff FSM plus registered outputs; no latches, nonblocking only.
// TESTING
// - Reset release, then rx 0x01,0xA0,0x10,0x55 at 4-cycle spacing:
//   - start_bit, then valid_cmd the next cycle.
//   - Writes idx0=0xA0, idx1=0x10, idx2=0x55.
//   - last_opds 1 cycle after the idx2 write.
// - rx 0x7F: start_bit, then cmd_err the next cycle; no valid_cmd. A following 0x04,0x33 frame completes normally.
// - rx 0x03,0x11,0x22, then abort for 1 cycle:
//   - No last_opds.
//   - Next frame 0x02,0x01,0x02 writes idx0=0x01, idx1=0x02 (count restarted).
// - rx_valid and opds_cnt_rst in the same cycle during S_COLLECT: no write, state S_IDLE, next byte taken as an opcode.
// - OPDS_CHECKSUM_EN:
//   - 0x04,0x33,0x37: last_opds.
//   - 0x04,0x33,0x00: cmd_err, no last_opds.
// - Assert rst_n low in S_COLLECT: all outputs 0 asynchronously; after release, a complete 0x02 frame passes.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared types, sizes and command table for the command/operand sequencer.
package comm_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_OPDS = 4;
  localparam int unsigned IDX_W    = $clog2(MAX_OPDS);
  localparam int unsigned CNT_W    = $clog2(MAX_OPDS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DECODE  = 2'd1,
    S_COLLECT = 2'd2,
    S_CHECK   = 2'd3
  } seq_state_t;

  localparam logic [DATA_W-1:0] CMD_WRITE = 8'h01;
  localparam logic [DATA_W-1:0] CMD_READ  = 8'h02;
  localparam logic [DATA_W-1:0] CMD_FILL  = 8'h03;
  localparam logic [DATA_W-1:0] CMD_PING  = 8'h04;

  // Operand count for an opcode; 0 marks an unknown opcode.
  function automatic logic [CNT_W-1:0] opds_for_cmd(input logic [DATA_W-1:0] opcode);
    logic [CNT_W-1:0] n;
    case (opcode)
      CMD_WRITE: n = CNT_W'(3);
      CMD_READ:  n = CNT_W'(2);
      CMD_FILL:  n = CNT_W'(4);
      CMD_PING:  n = CNT_W'(1);
      default:   n = CNT_W'(0);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cmd_opds_sequencer_cmd_table_rom.sv
// Combinational opcode lookup: validity and number of operands.
module cmd_table_rom
  import comm_pkg::*;
(
  input  logic [DATA_W-1:0] i_opcode,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_n_opds
);

  // Table lives in opds_for_cmd so it is edited in one place.
  always_comb begin
    o_n_opds = opds_for_cmd(i_opcode);
    o_valid  = (o_n_opds != CNT_W'(0));
  end

endmodule

// File: rtl/cmd_opds_sequencer.sv
// Frames received UART bytes into opcode + operands and writes operands
// into the operand register file. Optional trailing XOR checksum byte is
// enabled by defining OPDS_CHECKSUM_EN.
module cmd_opds_sequencer
  import comm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rx_valid,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_abort,
  input  logic              i_opds_cnt_rst,
  output logic              o_start_bit,
  output logic              o_valid_cmd,
  output logic              o_cmd_err,
  output logic [DATA_W-1:0] o_cmd_code,
  output logic              o_opd_wr_en,
  output logic [IDX_W-1:0]  o_opd_wr_idx,
  output logic [DATA_W-1:0] o_opd_wr_data,
  output logic              o_last_opds
);

  seq_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_count, w_count_nxt;
  logic [CNT_W-1:0]  r_n_opds, w_n_opds_nxt;
  logic              r_last_pend, w_last_pend_nxt;

  logic              r_start_bit, w_start_bit;
  logic              r_valid_cmd, w_valid_cmd;
  logic              r_cmd_err, w_cmd_err;
  logic [DATA_W-1:0] r_cmd_code, w_cmd_code;
  logic              r_opd_wr_en, w_opd_wr_en;
  logic [IDX_W-1:0]  r_opd_wr_idx, w_opd_wr_idx;
  logic [DATA_W-1:0] r_opd_wr_data, w_opd_wr_data;
  logic              r_last_opds, w_last_opds;

`ifdef OPDS_CHECKSUM_EN
  logic [DATA_W-1:0] r_xor, w_xor_nxt;
`endif

  logic              w_rom_valid;
  logic [CNT_W-1:0]  w_rom_n;
  logic              w_flush;
  logic              w_last_idx;

  cmd_table_rom u_rom (
    .i_opcode (r_cmd_code),
    .o_valid  (w_rom_valid),
    .o_n_opds (w_rom_n)
  );

  assign w_flush    = i_opds_cnt_rst | i_abort;
  assign w_last_idx = (CNT_W'(r_count) == (r_n_opds - CNT_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; cnt_rst/abort outrank any byte.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_flush && i_rx_valid) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_flush)          w_state_nxt = S_IDLE;
        else if (w_rom_valid) w_state_nxt = S_COLLECT;
        else                  w_state_nxt = S_IDLE;
      end
      S_COLLECT: begin
        if (w_flush) w_state_nxt = S_IDLE;
        else if (i_rx_valid && w_last_idx) begin
`ifdef OPDS_CHECKSUM_EN
          w_state_nxt = S_CHECK;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef OPDS_CHECKSUM_EN
      S_CHECK: begin
        if (w_flush || i_rx_valid) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    w_start_bit     = 1'b0;
    w_valid_cmd     = 1'b0;
    w_cmd_err       = 1'b0;
    w_cmd_code      = r_cmd_code;
    w_opd_wr_en     = 1'b0;
    w_opd_wr_idx    = r_opd_wr_idx;
    w_opd_wr_data   = r_opd_wr_data;
    w_last_opds     = r_last_pend;
    w_last_pend_nxt = 1'b0;
    w_count_nxt     = r_count;
    w_n_opds_nxt    = r_n_opds;
`ifdef OPDS_CHECKSUM_EN
    w_xor_nxt       = r_xor;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_flush && i_rx_valid) begin
          w_start_bit = 1'b1;
          w_cmd_code  = i_rx_data;
          w_count_nxt = IDX_W'(0);
`ifdef OPDS_CHECKSUM_EN
          w_xor_nxt   = i_rx_data;
`endif
        end
      end
      S_DECODE: begin
        w_count_nxt = IDX_W'(0);
        if (!w_flush) begin
          if (w_rom_valid) begin
            w_valid_cmd  = 1'b1;
            w_n_opds_nxt = w_rom_n;
          end else begin
            w_cmd_err = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (w_flush) begin
          w_count_nxt = IDX_W'(0);
        end else if (i_rx_valid) begin
          w_opd_wr_en   = 1'b1;
          w_opd_wr_idx  = r_count;
          w_opd_wr_data = i_rx_data;
`ifdef OPDS_CHECKSUM_EN
          w_xor_nxt     = r_xor ^ i_rx_data;
`endif
          if (w_last_idx) begin
            w_count_nxt = IDX_W'(0);
`ifndef OPDS_CHECKSUM_EN
            w_last_pend_nxt = 1'b1;
`endif
          end else begin
            w_count_nxt = r_count + IDX_W'(1);
          end
        end
      end
`ifdef OPDS_CHECKSUM_EN
      S_CHECK: begin
        if (!w_flush && i_rx_valid) begin
          if (i_rx_data == r_xor) w_last_opds = 1'b1;
          else                    w_cmd_err   = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_n_opds      <= '0;
      r_last_pend   <= 1'b0;
      r_start_bit   <= 1'b0;
      r_valid_cmd   <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_cmd_code    <= '0;
      r_opd_wr_en   <= 1'b0;
      r_opd_wr_idx  <= '0;
      r_opd_wr_data <= '0;
      r_last_opds   <= 1'b0;
`ifdef OPDS_CHECKSUM_EN
      r_xor         <= '0;
`endif
    end else begin
      r_count       <= w_count_nxt;
      r_n_opds      <= w_n_opds_nxt;
      r_last_pend   <= w_last_pend_nxt;
      r_start_bit   <= w_start_bit;
      r_valid_cmd   <= w_valid_cmd;
      r_cmd_err     <= w_cmd_err;
      r_cmd_code    <= w_cmd_code;
      r_opd_wr_en   <= w_opd_wr_en;
      r_opd_wr_idx  <= w_opd_wr_idx;
      r_opd_wr_data <= w_opd_wr_data;
      r_last_opds   <= w_last_opds;
`ifdef OPDS_CHECKSUM_EN
      r_xor         <= w_xor_nxt;
`endif
    end
  end

  assign o_start_bit   = r_start_bit;
  assign o_valid_cmd   = r_valid_cmd;
  assign o_cmd_err     = r_cmd_err;
  assign o_cmd_code    = r_cmd_code;
  assign o_opd_wr_en   = r_opd_wr_en;
  assign o_opd_wr_idx  = r_opd_wr_idx;
  assign o_opd_wr_data = r_opd_wr_data;
  assign o_last_opds   = r_last_opds;

endmodule
